// File: rtl/commit_trace_buffer_pkg.sv
// Shared constants, entry layout and helpers for the commit trace buffer.
// Entry layout is {instr, pre_pc, pc} with pc in the least significant bits.
package commit_trace_pkg;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam int          TRACE_W     = 160;
    localparam int          DROP_W      = 16;

    localparam int PC_LSB     = 0;
    localparam int PRE_PC_LSB = 64;
    localparam int INSTR_LSB  = 128;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pre_pc;
        logic [63:0] pc;
    } trace_entry_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side and trace-side signal bundle; master drives commits and consumer
// controls, slave is the buffer.
interface commit_trace_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic        commit_i_valid;
    logic [31:0] commit_i_instr;
    logic [63:0] commit_i_pc;
    logic [63:0] commit_i_pre_pc;
    logic        trace_i_ready;
    logic        trace_i_clear_ovf;
    logic        trace_o_valid;
    logic [31:0] trace_o_instr;
    logic [63:0] trace_o_pc;
    logic [63:0] trace_o_pre_pc;
    logic [AW:0] trace_o_count;
    logic        trace_o_overflow;
    logic [15:0] trace_o_drops;
    logic [63:0] trace_o_instret;
    logic        trace_o_halt;

    modport master (
        output commit_i_valid, commit_i_instr, commit_i_pc, commit_i_pre_pc,
        output trace_i_ready, trace_i_clear_ovf,
        input  trace_o_valid, trace_o_instr, trace_o_pc, trace_o_pre_pc,
        input  trace_o_count, trace_o_overflow, trace_o_drops, trace_o_instret, trace_o_halt
    );

    modport slave (
        input  commit_i_valid, commit_i_instr, commit_i_pc, commit_i_pre_pc,
        input  trace_i_ready, trace_i_clear_ovf,
        output trace_o_valid, trace_o_instr, trace_o_pc, trace_o_pre_pc,
        output trace_o_count, trace_o_overflow, trace_o_drops, trace_o_instret, trace_o_halt
    );

endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// Show-ahead synchronous FIFO; head data visible the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-record trace FIFO with instret, sticky overflow and drop counter; 1-cycle push-to-head latency.
// Never stalls retire: commits arriving while full (and not popping) are dropped and counted.
// Optional COMMIT_TRACE_EBREAK_HALT_EN: ebreak commit sets sticky halt, later commits are ignored.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_trace_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    trace_entry_t      wr_entry;
    logic [TRACE_W-1:0] rd_dat;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
    logic              halt;
    logic              commit_eff;
    logic              push;
    logic              pop;
    logic              drop;
    logic              overflow;
    logic [DROP_W-1:0] drops;
    logic [63:0]       instret;

`ifdef COMMIT_TRACE_EBREAK_HALT_EN
    assign commit_eff = bus.commit_i_valid && !halt;

    // The ebreak itself is still recorded; only commits after it are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (commit_eff && (bus.commit_i_instr == EBREAK_INSN)) begin
            halt <= 1'b1;
        end
    end
`else
    assign commit_eff = bus.commit_i_valid;
    assign halt       = 1'b0;
`endif

    assign pop  = !empty && bus.trace_i_ready;
    assign push = commit_eff && (!full || pop);
    assign drop = commit_eff && full && !pop;

    always_comb begin
        wr_entry        = '0;
        wr_entry.instr  = bus.commit_i_instr;
        wr_entry.pre_pc = bus.commit_i_pre_pc;
        wr_entry.pc     = bus.commit_i_pc;
    end

    sync_fifo_fwft #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (wr_entry),
        .pop      (pop),
        .pop_dat  (rd_dat),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // A drop in the same cycle as a clear restarts the counter at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drops    <= '0;
            instret  <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                drops    <= bus.trace_i_clear_ovf ? {{(DROP_W-1){1'b0}}, 1'b1} : sat_inc(drops);
            end else if (bus.trace_i_clear_ovf) begin
                overflow <= 1'b0;
                drops    <= '0;
            end
            if (commit_eff) instret <= instret + 64'd1;
        end
    end

    assign bus.trace_o_valid    = !empty;
    assign bus.trace_o_instr    = rd_dat[INSTR_LSB +: 32];
    assign bus.trace_o_pre_pc   = rd_dat[PRE_PC_LSB +: 64];
    assign bus.trace_o_pc       = rd_dat[PC_LSB +: 64];
    assign bus.trace_o_count    = count;
    assign bus.trace_o_overflow = overflow;
    assign bus.trace_o_drops    = drops;
    assign bus.trace_o_instret  = instret;
    assign bus.trace_o_halt     = halt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed and randomized checks of commit_trace_buffer against a queue-based reference model.
module tb_commit_trace_buffer;
    import commit_trace_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_trace_buffer_if #(.DEPTH(DEPTH)) bus();

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pre_pc;
    } rec_t;

    rec_t            q[$];
    longint unsigned m_instret;
    bit              m_ovf;
    int              m_drops;
    bit              m_halt;
    int              checks = 0;
    int              errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("valid",    {63'd0, bus.trace_o_valid},    {63'd0, q.size() != 0});
        check("count",    {60'd0, bus.trace_o_count},    64'(q.size()));
        check("overflow", {63'd0, bus.trace_o_overflow}, {63'd0, m_ovf});
        check("drops",    {48'd0, bus.trace_o_drops},    64'(m_drops));
        check("instret",  bus.trace_o_instret,           m_instret);
        check("halt",     {63'd0, bus.trace_o_halt},     {63'd0, m_halt});
        if (q.size() != 0) begin
            check("head_instr",  {32'd0, bus.trace_o_instr}, {32'd0, q[0].instr});
            check("head_pc",     bus.trace_o_pc,              q[0].pc);
            check("head_pre_pc", bus.trace_o_pre_pc,          q[0].pre_pc);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, then compare.
    task automatic step();
        bit   acc;
        bit   can_pop;
        bit   was_full;
        rec_t r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_instret = 0;
            m_ovf     = 0;
            m_drops   = 0;
            m_halt    = 0;
        end else begin
            acc      = bus.commit_i_valid && !m_halt;
            can_pop  = (q.size() != 0) && bus.trace_i_ready;
            was_full = (q.size() == DEPTH);
            if (can_pop) void'(q.pop_front());
            if (bus.trace_i_clear_ovf) begin
                m_ovf   = 0;
                m_drops = 0;
            end
            if (acc) begin
                m_instret++;
                if (!was_full || can_pop) begin
                    r.instr  = bus.commit_i_instr;
                    r.pc     = bus.commit_i_pc;
                    r.pre_pc = bus.commit_i_pre_pc;
                    q.push_back(r);
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
                if (bus.commit_i_instr == EBREAK_INSN) m_halt = 1;
`endif
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pre_pc);
        bus.commit_i_valid  = v;
        bus.commit_i_instr  = instr;
        bus.commit_i_pre_pc = pre_pc;
        bus.commit_i_pc     = pre_pc + 64'd4;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(1'b0, 32'h0, 64'h0);
        bus.trace_i_ready     = 1'b0;
        bus.trace_i_clear_ovf = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] v;
        v = $urandom;
        if (v == EBREAK_INSN) v = v ^ 32'h1;
        return v;
    endfunction

    task automatic fill(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, rand_insn(), base + 64'(4 * i));
            step();
        end
        drive(1'b0, 32'h0, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 64'h0);
        bus.trace_i_ready     = 1'b0;
        bus.trace_i_clear_ovf = 1'b0;
        step();
        step();
        check("rst_valid",   {63'd0, bus.trace_o_valid}, 64'd0);
        check("rst_instret", bus.trace_o_instret,        64'd0);
        rst = 1'b0;

        // Three commits streamed straight through.
        bus.trace_i_ready = 1'b1;
        fill(3, 64'h8000_0000);
        step();
        step();
        check("s1_instret", bus.trace_o_instret,        64'd3);
        check("s1_count",   {60'd0, bus.trace_o_count}, 64'd0);

        // Overfill with the consumer stalled, then drain in order.
        reset_dut();
        fill(10, 64'h1000_0000);
        step();
        check("s2_count",    {60'd0, bus.trace_o_count},    64'd8);
        check("s2_overflow", {63'd0, bus.trace_o_overflow}, 64'd1);
        check("s2_drops",    {48'd0, bus.trace_o_drops},    64'd2);
        check("s2_instret",  bus.trace_o_instret,           64'd10);
        bus.trace_i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("s2_drain_order", bus.trace_o_pre_pc, 64'h1000_0000 + 64'(4 * i));
            step();
        end
        check("s2_empty", {63'd0, bus.trace_o_valid}, 64'd0);

        // Full FIFO with simultaneous push and pop.
        reset_dut();
        fill(8, 64'h2000_0000);
        drive(1'b1, rand_insn(), 64'h2000_1000);
        bus.trace_i_ready = 1'b1;
        step();
        drive(1'b0, 32'h0, 64'h0);
        check("s3_count", {60'd0, bus.trace_o_count}, 64'd8);
        check("s3_drops", {48'd0, bus.trace_o_drops}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("s3_last", bus.trace_o_pre_pc, 64'h2000_1000);
            step();
        end

        // Clear racing a drop, then clear alone.
        reset_dut();
        fill(10, 64'h3000_0000);
        drive(1'b1, rand_insn(), 64'h3000_1000);
        bus.trace_i_clear_ovf = 1'b1;
        step();
        check("s4_race_ovf",   {63'd0, bus.trace_o_overflow}, 64'd1);
        check("s4_race_drops", {48'd0, bus.trace_o_drops},    64'd1);
        drive(1'b0, 32'h0, 64'h0);
        step();
        bus.trace_i_clear_ovf = 1'b0;
        check("s4_clr_ovf",   {63'd0, bus.trace_o_overflow}, 64'd0);
        check("s4_clr_drops", {48'd0, bus.trace_o_drops},    64'd0);

        // Reset with entries queued and a commit in flight.
        reset_dut();
        fill(5, 64'h4000_0000);
        drive(1'b1, rand_insn(), 64'h4000_1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        check("s5_valid",   {63'd0, bus.trace_o_valid},    64'd0);
        check("s5_count",   {60'd0, bus.trace_o_count},    64'd0);
        check("s5_instret", bus.trace_o_instret,           64'd0);
        check("s5_ovf",     {63'd0, bus.trace_o_overflow}, 64'd0);

        // addi, ebreak, addi.
        reset_dut();
        drive(1'b1, 32'h0000_0013, 64'h5000_0000); step();
        drive(1'b1, EBREAK_INSN,   64'h5000_0004); step();
        drive(1'b1, 32'h0000_0013, 64'h5000_0008); step();
        drive(1'b0, 32'h0, 64'h0);
        step();
`ifdef COMMIT_TRACE_EBREAK_HALT_EN
        check("s6_count",   {60'd0, bus.trace_o_count}, 64'd2);
        check("s6_halt",    {63'd0, bus.trace_o_halt},  64'd1);
        check("s6_instret", bus.trace_o_instret,        64'd2);
`else
        check("s6_count",   {60'd0, bus.trace_o_count}, 64'd3);
        check("s6_halt",    {63'd0, bus.trace_o_halt},  64'd0);
        check("s6_instret", bus.trace_o_instret,        64'd3);
`endif

        // Randomized traffic with alternating consumer pressure.
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive(($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 79) == 0) ? EBREAK_INSN : rand_insn(),
                  {$urandom, $urandom});
            bus.trace_i_ready     = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                                        : ($urandom_range(0, 3) != 0);
            bus.trace_i_clear_ovf = ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
